snoop_controller: RTL and testbench
===================================

Name: snoop_controller

Overview:
- Bus-side (snooping) half of the invalidate-protocol snoopy cache. It is the responder to the bus commands that another cache's CPU-side controller initiates.
- It watches the shared bus whenever this cache is not the bus owner and looks up the snooped address in the cache's snoop port.
- It supplies MODIFIED data word by word (intercepting memory), downgrades or invalidates local lines, and raises the invalidate acknowledgement that initiators wait on.

Parameters:
OFFSET_WIDTH, 4, word-offset bits per block
INDEX_WIDTH, 4, set-index bits
TAG_WIDTH, 8, tag bits
DATA_WIDTH, 16, bus/cache word width
STATE_WIDTH, 2, coherence state width; encodings: INVALID=0, SHARED=1, MODIFIED=2

Ports:
clock  in  1  system clock
reset  in  1  reset
own_grant  in  1  arbiter grant to this cache; bus is ignored while high
bus_command  in  3  NONE=0, BUS_READ=1, BUS_READ_EXCLUSIVE=2, BUS_INVALIDATE=3, BUS_WRITEBACK=4
bus_address  in  TAG+INDEX+OFFSET  word address driven by the initiator
bus_read_enabled  in  1  initiator word-read strobe, held until function complete
bus_data_out  out  DATA_WIDTH  word supplied by this cache
bus_intercept  out  1  this cache owns the data phase; memory must not complete
bus_function_complete  out  1  one-cycle completion pulse for the supplied word
bus_invalidated  out  1  acknowledge: line absent or invalid here
cache_tag  out  TAG_WIDTH  snoop lookup tag
cache_index  out  INDEX_WIDTH  snoop lookup index
cache_offset  out  OFFSET_WIDTH  snoop lookup word offset
cache_hit  in  1  snoop tag match, combinational
cache_state_out  in  STATE_WIDTH  state of the indexed line
cache_data_out  in  DATA_WIDTH  word at index/offset
cache_state_in  out  STATE_WIDTH  new state to write
cache_write_state  out  1  state write strobe, one cycle

Behaviour:
- Interface decision: reset is named reset and is synchronous, active-high; the clock is named clock.
- cache_tag, cache_index and cache_offset are combinational slices of bus_address: the tag is the top field, the offset is the low field.
- active = !own_grant && bus_command != NONE.
- Reset values: all registered outputs are 0 (bus_data_out=0, cache_state_in=INVALID). The FSM goes to IDLE.
- Reset mid-operation takes effect on the next edge. A line interrupted mid-supply stays MODIFIED.
- FSM states: IDLE, SUPPLY, RELEASE, UPDATE.
- IDLE transitions, checked in priority order:
  - Supply case: active, command is READ or READ_EXCLUSIVE, cache_hit, state==MODIFIED and bus_read_enabled. Register cache_data_out into bus_data_out and set bus_intercept<=1 and bus_function_complete<=1. Go to SUPPLY. Latency from strobe to complete is 1 cycle.
  - Invalidate case: active, command is READ_EXCLUSIVE or INVALIDATE, cache_hit and state==SHARED. Set cache_state_in<=INVALID and cache_write_state<=1. Go to UPDATE.
  - BUS_WRITEBACK, or a miss/INVALID line: no action; stay in IDLE.
- SUPPLY: bus_function_complete<=0. Go to RELEASE.
- RELEASE: wait for bus_read_enabled==0, then set bus_intercept<=0.
  - If offset is all ones (last word): write state SHARED for BUS_READ or INVALID for BUS_READ_EXCLUSIVE, with cache_write_state<=1, and go to UPDATE.
  - Otherwise return to IDLE for the next word.
- UPDATE: cache_write_state<=0. Go to IDLE.
- bus_invalidated is registered and updated every cycle. It is 1 when the FSM is in IDLE, active, command is READ_EXCLUSIVE or INVALIDATE, and (!cache_hit or state==INVALID). Otherwise it is 0.
  - It stays high for as long as the command persists; the initiator ANDs the acknowledgements from all caches.
- Abort: if active drops in SUPPLY or RELEASE (command NONE or own_grant rises), clear intercept and complete and go to IDLE with no state write.
- Simultaneous supply and invalidate conditions cannot both hold, because a line cannot be both MODIFIED and SHARED.
- bus_function_complete is never high for two consecutive cycles.
- Memory contract: memory completion latency is at least 2 cycles, and memory samples bus_intercept before completing.

Test Plan:
- Remote BUS_READ of a MODIFIED line, 16 words with strobes released after each complete: each word has complete 1 cycle after its strobe and bus_data_out equals the cache word; after word 15, cache_write_state pulses with SHARED.
- BUS_READ_EXCLUSIVE on a MODIFIED line with data 0xA5A5 at offset 0: first word supplied as 0xA5A5; after offset 15, state is written INVALID and bus_invalidated goes 1 the following idle cycle.
- BUS_INVALIDATE hitting a SHARED line: state write to INVALID within 1 cycle, then bus_invalidated=1 while the command is held; a miss gives bus_invalidated=1 the cycle after the command appears.
- own_grant=1 with a matching BUS_READ on a MODIFIED line: no intercept, no complete, no state write.
- Reset asserted in RELEASE at word 7: all outputs are 0 next cycle and no cache_write_state pulse occurs. Separately, the command dropping to NONE in SUPPLY returns the FSM to IDLE with the line still MODIFIED.

Source files
------------

// File: rtl/snoop_controller_if.sv
// Shared-bus signals seen by the snooping half of a cache.
// The initiator drives command/address/strobe; the snooper answers with data and acknowledgements.
interface snoop_controller_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [2:0]            bus_command;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic                  bus_read_enabled;
    logic [DATA_WIDTH-1:0] bus_data_out;
    logic                  bus_intercept;
    logic                  bus_function_complete;
    logic                  bus_invalidated;

    modport master (
        output bus_command, bus_address, bus_read_enabled,
        input  bus_data_out, bus_intercept, bus_function_complete, bus_invalidated
    );

    modport slave (
        input  bus_command, bus_address, bus_read_enabled,
        output bus_data_out, bus_intercept, bus_function_complete, bus_invalidated
    );
endinterface

// File: rtl/snoop_controller.sv
// Bus-side responder of the invalidate-protocol snoopy cache: supplies MODIFIED words,
// downgrades/invalidates local lines and acknowledges invalidations.
module snoop_controller #(
    parameter int OFFSET_WIDTH = 4,
    parameter int INDEX_WIDTH  = 4,
    parameter int TAG_WIDTH    = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int STATE_WIDTH  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    own_grant,
    snoop_controller_if.slave       bus,
    output logic [TAG_WIDTH-1:0]    cache_tag,
    output logic [INDEX_WIDTH-1:0]  cache_index,
    output logic [OFFSET_WIDTH-1:0] cache_offset,
    input  logic                    cache_hit,
    input  logic [STATE_WIDTH-1:0]  cache_state_out,
    input  logic [DATA_WIDTH-1:0]   cache_data_out,
    output logic [STATE_WIDTH-1:0]  cache_state_in,
    output logic                    cache_write_state
);
    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_RDX   = 3'd2;
    localparam logic [2:0] CMD_INVAL = 3'd3;

    localparam logic [STATE_WIDTH-1:0] ST_INVALID  = STATE_WIDTH'(0);
    localparam logic [STATE_WIDTH-1:0] ST_SHARED   = STATE_WIDTH'(1);
    localparam logic [STATE_WIDTH-1:0] ST_MODIFIED = STATE_WIDTH'(2);

    typedef enum logic [1:0] {S_IDLE, S_SUPPLY, S_RELEASE, S_UPDATE} state_t;

    state_t                  r_state,       w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_data,        w_data_nxt;
    logic                    r_intercept,   w_intercept_nxt;
    logic                    r_complete,    w_complete_nxt;
    logic                    r_invalidated, w_invalidated_nxt;
    logic                    r_write,       w_write_nxt;
    logic [STATE_WIDTH-1:0]  r_state_in,    w_state_in_nxt;

    logic w_active, w_is_read, w_is_rdx, w_is_inval;
    logic w_hit_mod, w_hit_shr, w_last_word;

    assign cache_offset = bus.bus_address[OFFSET_WIDTH-1:0];
    assign cache_index  = bus.bus_address[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cache_tag    = bus.bus_address[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH];

    assign w_active    = !own_grant && (bus.bus_command != CMD_NONE);
    assign w_is_read   = (bus.bus_command == CMD_READ);
    assign w_is_rdx    = (bus.bus_command == CMD_RDX);
    assign w_is_inval  = (bus.bus_command == CMD_INVAL);
    assign w_hit_mod   = cache_hit && (cache_state_out == ST_MODIFIED);
    assign w_hit_shr   = cache_hit && (cache_state_out == ST_SHARED);
    assign w_last_word = (cache_offset == {OFFSET_WIDTH{1'b1}});

    assign bus.bus_data_out          = r_data;
    assign bus.bus_intercept         = r_intercept;
    assign bus.bus_function_complete = r_complete;
    assign bus.bus_invalidated       = r_invalidated;
    assign cache_state_in            = r_state_in;
    assign cache_write_state         = r_write;

    // Next-state and next-output decode; complete and write are single-cycle strobes by default.
    always_comb begin
        w_state_nxt       = r_state;
        w_data_nxt        = r_data;
        w_intercept_nxt   = r_intercept;
        w_complete_nxt    = 1'b0;
        w_write_nxt       = 1'b0;
        w_state_in_nxt    = r_state_in;
        w_invalidated_nxt = (r_state == S_IDLE) && w_active && (w_is_rdx || w_is_inval) &&
                            (!cache_hit || (cache_state_out == ST_INVALID));
        case (r_state)
            S_IDLE: begin
                if (w_active && (w_is_read || w_is_rdx) && w_hit_mod && bus.bus_read_enabled) begin
                    w_data_nxt      = cache_data_out;
                    w_intercept_nxt = 1'b1;
                    w_complete_nxt  = 1'b1;
                    w_state_nxt     = S_SUPPLY;
                end else if (w_active && (w_is_rdx || w_is_inval) && w_hit_shr) begin
                    w_state_in_nxt  = ST_INVALID;
                    w_write_nxt     = 1'b1;
                    w_state_nxt     = S_UPDATE;
                end else begin
                    w_state_nxt     = S_IDLE;
                end
            end
            S_SUPPLY: begin
                if (!w_active) begin
                    w_intercept_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_state_nxt     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // An aborted burst leaves the line MODIFIED: no state write on this path.
                if (!w_active) begin
                    w_intercept_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else if (!bus.bus_read_enabled) begin
                    w_intercept_nxt = 1'b0;
                    if (w_last_word) begin
                        w_state_in_nxt = w_is_read ? ST_SHARED : ST_INVALID;
                        w_write_nxt    = 1'b1;
                        w_state_nxt    = S_UPDATE;
                    end else begin
                        w_state_nxt    = S_IDLE;
                    end
                end else begin
                    w_state_nxt     = S_RELEASE;
                end
            end
            S_UPDATE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_intercept_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_data        <= {DATA_WIDTH{1'b0}};
            r_intercept   <= 1'b0;
            r_complete    <= 1'b0;
            r_invalidated <= 1'b0;
            r_write       <= 1'b0;
            r_state_in    <= ST_INVALID;
        end else begin
            r_state       <= w_state_nxt;
            r_data        <= w_data_nxt;
            r_intercept   <= w_intercept_nxt;
            r_complete    <= w_complete_nxt;
            r_invalidated <= w_invalidated_nxt;
            r_write       <= w_write_nxt;
            r_state_in    <= w_state_in_nxt;
        end
    end
endmodule

// File: tb/tb_snoop_controller.sv
// Directed bench for snoop_controller: a cache array and a bus-level reference model,
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_snoop_controller;
    logic        clock = 1'b0;
    logic        reset;
    logic        own_grant;
    logic [7:0]  cache_tag;
    logic [3:0]  cache_index;
    logic [3:0]  cache_offset;
    logic        cache_hit;
    logic [1:0]  cache_state_out;
    logic [15:0] cache_data_out;
    logic [1:0]  cache_state_in;
    logic        cache_write_state;

    snoop_controller_if bif ();

    snoop_controller dut (
        .clock(clock), .reset(reset), .own_grant(own_grant), .bus(bif),
        .cache_tag(cache_tag), .cache_index(cache_index), .cache_offset(cache_offset),
        .cache_hit(cache_hit), .cache_state_out(cache_state_out),
        .cache_data_out(cache_data_out), .cache_state_in(cache_state_in),
        .cache_write_state(cache_write_state)
    );

    always #5 clock = ~clock;

    // Cache contents seen through the snoop port
    logic [7:0]  tag_a  [16];
    logic [15:0] data_a [16][16];
    logic [1:0]  st_a   [16] = '{default: 2'd0};
    logic        ld_en  = 1'b0;
    logic [3:0]  ld_idx = 4'd0;
    logic [1:0]  ld_st  = 2'd0;

    assign cache_hit       = (tag_a[cache_index] == cache_tag);
    assign cache_state_out = st_a[cache_index];
    assign cache_data_out  = data_a[cache_index][cache_offset];

    typedef struct packed {
        logic [15:0] data;
        logic        icpt;
        logic        cmpl;
        logic        inv;
        logic        wr;
        logic [1:0]  st;
    } model_t;

    model_t m = '0;
    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    // Bus-level response rules: a burst is "in progress" while intercept is held;
    // a state write occupies one cycle; otherwise the snooper is idle.
    function automatic model_t step(model_t p, logic rst, logic grant, logic [2:0] cmd,
                                    logic [15:0] addr, logic rd);
        model_t n;
        logic [3:0] idx, off;
        logic hit, act, idle;
        logic [1:0] st;
        idx  = addr[7:4];
        off  = addr[3:0];
        hit  = (tag_a[idx] == addr[15:8]);
        st   = st_a[idx];
        act  = !grant && (cmd != 3'd0);
        idle = !p.icpt && !p.wr;
        n = p;
        n.cmpl = 1'b0;
        n.wr   = 1'b0;
        n.inv  = idle && act && (cmd == 3'd2 || cmd == 3'd3) && (!hit || st == 2'd0);
        if (rst) begin
            n = '0;
        end else if (p.wr) begin
            n.icpt = 1'b0;
        end else if (p.icpt) begin
            if (!act) begin
                n.icpt = 1'b0;
            end else if (!p.cmpl && !rd) begin
                n.icpt = 1'b0;
                if (off == 4'hF) begin
                    n.wr = 1'b1;
                    n.st = (cmd == 3'd1) ? 2'd1 : 2'd0;
                end
            end
        end else if (act && (cmd == 3'd1 || cmd == 3'd2) && hit && st == 2'd2 && rd) begin
            n.data = data_a[idx][off];
            n.icpt = 1'b1;
            n.cmpl = 1'b1;
        end else if (act && (cmd == 3'd2 || cmd == 3'd3) && hit && st == 2'd1) begin
            n.st = 2'd0;
            n.wr = 1'b1;
        end
        return n;
    endfunction

    // Advance the model and the cache state array on each clock edge.
    always @(posedge clock) begin
        m <= step(m, reset, own_grant, bif.bus_command, bif.bus_address, bif.bus_read_enabled);
        if (cache_write_state)
            st_a[cache_index] <= cache_state_in;
        else if (ld_en)
            st_a[ld_idx] <= ld_st;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison away from the active edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("data_out",   32'(bif.bus_data_out),          32'(m.data));
            check("intercept",  32'(bif.bus_intercept),         32'(m.icpt));
            check("complete",   32'(bif.bus_function_complete), 32'(m.cmpl));
            check("invalidated",32'(bif.bus_invalidated),       32'(m.inv));
            check("write_state",32'(cache_write_state),         32'(m.wr));
            check("state_in",   32'(cache_state_in),            32'(m.st));
            check("tag",        32'(cache_tag),    32'(bif.bus_address[15:8]));
            check("index",      32'(cache_index),  32'(bif.bus_address[7:4]));
            check("offset",     32'(cache_offset), 32'(bif.bus_address[3:0]));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic load(input logic [3:0] idx, input logic [1:0] st);
        ld_idx = idx;
        ld_st  = st;
        ld_en  = 1'b1;
        cyc();
        ld_en  = 1'b0;
    endtask

    task automatic read_word(input logic [2:0] c, input logic [7:0] tg, input logic [3:0] ix,
                             input logic [3:0] w);
        bif.bus_command      = c;
        bif.bus_address      = {tg, ix, w};
        bif.bus_read_enabled = 1'b1;
        cyc();
        check("strobe_to_complete", 32'(bif.bus_function_complete), 32'd1);
        check("word_value", 32'(bif.bus_data_out), 32'(data_a[ix][w]));
        bif.bus_read_enabled = 1'b0;
        for (int k = 0; k < 4 && bif.bus_intercept; k++) cyc();
        check("intercept_release", 32'(bif.bus_intercept), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        own_grant = 1'b0;
        bif.bus_command = 3'd0;
        bif.bus_address = 16'h0000;
        bif.bus_read_enabled = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tag_a[i] = 8'hFF;
            for (int w = 0; w < 16; w++)
                data_a[i][w] = 16'(i * 4096 + w * 257 + 16'h0123);
        end
        tag_a[5] = 8'hA1;
        tag_a[6] = 8'hB2;
        tag_a[3] = 8'h33;
        tag_a[7] = 8'hC3;
        data_a[6][0] = 16'hA5A5;

        cyc();
        cmp_en = 1'b1;
        cyc();
        check("reset_intercept", 32'(bif.bus_intercept), 32'd0);
        check("reset_data", 32'(bif.bus_data_out), 32'd0);
        check("reset_state_in", 32'(cache_state_in), 32'd0);
        reset = 1'b0;
        load(4'd5, 2'd2);
        load(4'd6, 2'd2);
        load(4'd3, 2'd1);
        load(4'd7, 2'd2);

        // Remote BUS_READ of a whole MODIFIED block
        for (int w = 0; w < 16; w++) read_word(3'd1, 8'hA1, 4'd5, 4'(w));
        check("read_last_write", 32'(cache_write_state), 32'd1);
        check("read_last_state", 32'(cache_state_in), 32'd1);
        bif.bus_command = 3'd0;
        cyc();
        check("read_line_shared", 32'(st_a[5]), 32'd1);

        // BUS_READ_EXCLUSIVE of a MODIFIED block
        for (int w = 0; w < 16; w++) begin
            read_word(3'd2, 8'hB2, 4'd6, 4'(w));
            if (w == 0) check("rdx_first_word", 32'(bif.bus_data_out), 32'h0000A5A5);
        end
        check("rdx_last_write", 32'(cache_write_state), 32'd1);
        check("rdx_last_state", 32'(cache_state_in), 32'd0);
        cyc();
        cyc();
        check("rdx_invalidated", 32'(bif.bus_invalidated), 32'd1);
        bif.bus_command = 3'd0;
        cyc();

        // BUS_INVALIDATE on a SHARED line, then on a miss
        bif.bus_command = 3'd3;
        bif.bus_address = {8'h33, 4'd3, 4'd0};
        cyc();
        check("inval_write", 32'(cache_write_state), 32'd1);
        check("inval_state", 32'(cache_state_in), 32'd0);
        cyc();
        cyc();
        check("inval_ack", 32'(bif.bus_invalidated), 32'd1);
        cyc();
        check("inval_ack_held", 32'(bif.bus_invalidated), 32'd1);
        bif.bus_command = 3'd0;
        cyc();
        bif.bus_command = 3'd3;
        bif.bus_address = {8'h44, 4'd9, 4'd0};
        cyc();
        check("miss_ack", 32'(bif.bus_invalidated), 32'd1);
        bif.bus_command = 3'd4;
        bif.bus_address = {8'hC3, 4'd7, 4'd0};
        cyc();
        cyc();
        check("writeback_no_intercept", 32'(bif.bus_intercept), 32'd0);
        bif.bus_command = 3'd0;
        cyc();

        // Bus owner ignores its own command
        own_grant = 1'b1;
        bif.bus_command = 3'd1;
        bif.bus_read_enabled = 1'b1;
        cyc(); cyc(); cyc();
        check("grant_no_intercept", 32'(bif.bus_intercept), 32'd0);
        check("grant_no_complete", 32'(bif.bus_function_complete), 32'd0);
        own_grant = 1'b0;
        bif.bus_read_enabled = 1'b0;
        bif.bus_command = 3'd0;
        cyc();

        // Reset while waiting for the strobe to drop at word 7
        for (int w = 0; w < 7; w++) read_word(3'd1, 8'hC3, 4'd7, 4'(w));
        bif.bus_address = {8'hC3, 4'd7, 4'd7};
        bif.bus_read_enabled = 1'b1;
        cyc();
        cyc();
        check("release_intercept", 32'(bif.bus_intercept), 32'd1);
        reset = 1'b1;
        cyc();
        check("rst_intercept", 32'(bif.bus_intercept), 32'd0);
        check("rst_complete", 32'(bif.bus_function_complete), 32'd0);
        check("rst_data", 32'(bif.bus_data_out), 32'd0);
        check("rst_write", 32'(cache_write_state), 32'd0);
        reset = 1'b0;
        bif.bus_read_enabled = 1'b0;
        bif.bus_command = 3'd0;
        cyc(); cyc(); cyc();
        check("rst_line_modified", 32'(st_a[7]), 32'd2);

        // Command withdrawn during SUPPLY
        bif.bus_command = 3'd1;
        bif.bus_address = {8'hC3, 4'd7, 4'd3};
        bif.bus_read_enabled = 1'b1;
        cyc();
        check("abort_supply", 32'(bif.bus_function_complete), 32'd1);
        bif.bus_command = 3'd0;
        cyc();
        check("abort_intercept", 32'(bif.bus_intercept), 32'd0);
        bif.bus_read_enabled = 1'b0;
        cyc(); cyc();
        check("abort_line_modified", 32'(st_a[7]), 32'd2);

        cmp_en = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
